// File: rtl/zp_mac_accumulator_if.sv
// Job/term/result handshake bundle for the zero-point MAC accumulator.
interface zp_mac_accumulator_if #(
  parameter int OUT_W = 16,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       diff_in;
  logic [7:0]       wt_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] acc_out;
  logic             sat_flag;
  logic             busy;

  modport master (
    output start, len, in_valid, diff_in, wt_in, out_ready,
    input  in_ready, out_valid, acc_out, sat_flag, busy
  );

  modport slave (
    input  start, len, in_valid, diff_in, wt_in, out_ready,
    output in_ready, out_valid, acc_out, sat_flag, busy
  );
endinterface

// File: rtl/zp_mac_accumulator.sv
// Sequential MAC after the zero-point subtractor; result valid 2 cycles after the last accepted term.
// in_ready is low outside ACCUM; the saturated result is held in DONE until out_ready.
module zp_mac_accumulator #(
  parameter int ACC_W = 24,  // must be >= 16 + LEN_W so the sum never wraps
  parameter int OUT_W = 16,
  parameter int LEN_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  zp_mac_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  state_t                   state, state_nxt;
  logic [LEN_W-1:0]         remaining;
  logic signed [15:0]       p;
  logic                     pvalid;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [15:0]       diff_ext, wt_ext;
  logic [OUT_W-1:0]         acc_out_q, clamp_val;
  logic                     sat_q, clamp_sat;
  logic                     in_ready, beat, job_start;

  assign diff_ext  = {{8{bus.diff_in[7]}}, bus.diff_in};
  assign wt_ext    = {{8{bus.wt_in[7]}}, bus.wt_in};
  assign in_ready  = (state == ACCUM) && (remaining != '0);
  assign beat      = bus.in_valid && in_ready;
  assign job_start = (state == IDLE) && bus.start;

  // Stage-2 sum is also what DRAIN clamps, so the last product reaches the output register directly.
  assign acc_sum = pvalid ? acc + {{(ACC_W-16){p[15]}}, p} : acc;

  always_comb begin
    clamp_val = acc_sum[OUT_W-1:0];
    clamp_sat = 1'b0;
    if (acc_sum > SAT_MAX) begin
      clamp_val = OUT_MAX;
      clamp_sat = 1'b1;
    end else if (acc_sum < SAT_MIN) begin
      clamp_val = OUT_MIN;
      clamp_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = (bus.len == '0) ? DRAIN : ACCUM;
      ACCUM: if (beat && remaining == LEN_W'(1)) state_nxt = DRAIN;
      DRAIN: state_nxt = DONE;
      DONE:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      p         <= '0;
      pvalid    <= 1'b0;
      acc       <= '0;
      acc_out_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      pvalid <= beat;
      if (beat) p <= diff_ext * wt_ext;

      if (job_start) begin
        acc       <= '0;
        remaining <= bus.len;
      end else begin
        acc <= acc_sum;
        if (beat) remaining <= remaining - LEN_W'(1);
      end

      if (state == DRAIN) begin
        acc_out_q <= clamp_val;
        sat_q     <= clamp_sat;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.acc_out   = acc_out_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_zp_mac_accumulator.sv
// Scoreboard bench for zp_mac_accumulator: results, latency, backpressure, zero length, reset abort.
module tb_zp_mac_accumulator;
  localparam int ACC_W = 24;
  localparam int OUT_W = 16;
  localparam int LEN_W = 8;

  typedef struct {
    int acc;
    int sat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];
  int   job_d[$];
  int   job_w[$];

  zp_mac_accumulator_if #(.OUT_W(OUT_W), .LEN_W(LEN_W)) bus ();

  zp_mac_accumulator #(.ACC_W(ACC_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_job();
    job_d.delete();
    job_w.delete();
  endtask

  task automatic add_beat(input int d, input int w);
    job_d.push_back(d);
    job_w.push_back(w);
  endtask

  // Presents beats in order, retrying each until the DUT shows in_ready; returns the last accept cycle.
  task automatic drive_beats(input int n, input bit bubbles, output int last_cyc);
    bit got;
    int tmo;
    last_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.diff_in  = 8'(job_d[i]);
      bus.wt_in    = 8'(job_w[i]);
      got = 1'b0;
      tmo = 0;
      while (!got && tmo < 20) begin
        @(negedge clk);
        if (bus.in_ready) begin
          got = 1'b1;
          last_cyc = cyc;
        end
        @(posedge clk);
        #1;
        tmo++;
      end
      if (!got) chk("in_ready_timeout", int'(bus.in_ready), 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int ref_cyc, input int bp, input bit start_in_done,
                             output bit rdy_seen);
    int   n;
    int   hold_acc;
    int   hold_sat;
    exp_t e;
    rdy_seen = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    if (!bus.out_valid) begin
      chk("out_valid_timeout", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      return;
    end
    chk("latency", cyc - ref_cyc, 2);
    hold_acc = int'($signed(bus.acc_out));
    hold_sat = int'(bus.sat_flag);
    for (int i = 0; i < bp; i++) begin
      if (start_in_done && i == 1) begin
        bus.start = 1'b1;
        bus.len   = 8'd3;
      end
      @(negedge clk);
      chk("bp_acc_stable", int'($signed(bus.acc_out)), hold_acc);
      chk("bp_sat_stable", int'(bus.sat_flag), hold_sat);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_busy", int'(bus.busy), 1);
      chk("bp_out_valid", int'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_empty", int'(bus.out_valid), 0);
    end else begin
      e = sb.pop_front();
      chk("acc_out", int'($signed(bus.acc_out)), e.acc);
      chk("sat_flag", int'(bus.sat_flag), e.sat);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    @(negedge clk);
    chk("post_hs_out_valid", int'(bus.out_valid), 0);
    chk("post_hs_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int n, input bit bubbles, input int bp, input bit start_in_done,
                         output bit rdy_seen);
    longint sum;
    exp_t   e;
    int     start_cyc;
    int     last_cyc;
    sum = 0;
    for (int i = 0; i < n; i++) sum += longint'(job_d[i]) * longint'(job_w[i]);
    if (sum > 32767) begin
      e.acc = 32767;  e.sat = 1;
    end else if (sum < -32768) begin
      e.acc = -32768; e.sat = 1;
    end else begin
      e.acc = int'(sum); e.sat = 0;
    end
    sb.push_back(e);
    bus.start = 1'b1;
    bus.len   = 8'(n);
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drive_beats(n, bubbles, last_cyc);
    if (n == 0) last_cyc = start_cyc;
    wait_result(last_cyc, bp, start_in_done, rdy_seen);
  endtask

  initial begin
    bit rdy_seen;
    int last;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.diff_in   = '0;
    bus.wt_in     = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_acc_out", int'($signed(bus.acc_out)), 0);
    chk("rst_sat_flag", int'(bus.sat_flag), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    clear_job(); add_beat(5, 2); add_beat(-3, 4); add_beat(127, -1);
    run_job(3, 1'b0, 0, 1'b0, rdy_seen);

    clear_job(); repeat (4) add_beat(-128, -128);
    run_job(4, 1'b0, 0, 1'b0, rdy_seen);

    clear_job(); repeat (4) add_beat(-128, 127);
    run_job(4, 1'b0, 0, 1'b0, rdy_seen);

    clear_job(); add_beat(5, 2); add_beat(-3, 4); add_beat(127, -1);
    run_job(3, 1'b1, 0, 1'b0, rdy_seen);

    clear_job(); add_beat(100, 100); add_beat(-50, 3);
    run_job(2, 1'b0, 5, 1'b1, rdy_seen);

    clear_job();
    run_job(0, 1'b0, 0, 1'b0, rdy_seen);
    chk("zero_len_in_ready", int'(rdy_seen), 0);

    clear_job();
    for (int i = 0; i < 255; i++) add_beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
    run_job(255, 1'b0, 0, 1'b0, rdy_seen);

    clear_job(); repeat (4) add_beat(-128, 127);
    run_job(4, 1'b0, 0, 1'b0, rdy_seen);

    clear_job(); for (int i = 1; i <= 5; i++) add_beat(i * 7, 3);
    bus.start = 1'b1;
    bus.len   = 8'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drive_beats(2, 1'b0, last);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_in_ready", int'(bus.in_ready), 0);
    chk("abort_acc_out", int'($signed(bus.acc_out)), 0);
    chk("abort_sat_flag", int'(bus.sat_flag), 0);
    chk("abort_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    clear_job(); add_beat(10, 10);
    run_job(1, 1'b0, 0, 1'b0, rdy_seen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/zp_mac_accumulator.md
Name: zp_mac_accumulator

Overview:
- Sequential multiply-accumulate stage directly downstream of the 8-bit zero-point subtractor in the reconfigurable MAC datapath.
- Consumes a stream of signed 8-bit differences (activation minus zero point) paired with signed 8-bit weights.
- Multiplies each pair, accumulates a programmed number of terms, and presents one saturated dot-product result per job over a valid/ready output handshake.

Parameters:
- ACC_W, 24, internal accumulator width; must be ≥ 16+LEN_W so it can never overflow.
- OUT_W, 16, result width; the final accumulator value is saturated to the signed OUT_W range.
- LEN_W, 8, width of the term-count input.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begins a job; sampled only in IDLE
- len  in  LEN_W  number of terms in the job; sampled with start
- in_valid  in  1  diff_in/wt_in valid
- in_ready  out  1  stage accepts a term this cycle
- diff_in  in  8  signed difference from the subtractor
- wt_in  in  8  signed weight
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- acc_out  out  OUT_W  saturated signed dot product
- sat_flag  out  1  result was clamped
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all registers clear; state=IDLE. in_ready=0, out_valid=0, acc_out=0, sat_flag=0, busy=0.
- Reset mid-job: the job is aborted immediately, with no partial result. A start after reset release is accepted normally.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - On start with len≠0: latch remaining=len, clear acc, go to ACCUM.
  - On start with len=0: clear acc, go to DRAIN. out_valid then rises 2 cycles after start with acc_out=0.
- ACCUM:
  - in_ready=1 while remaining≠0.
  - A beat is accepted on in_valid & in_ready. Bubbles (in_valid=0) are allowed and do not advance the count.
  - Stage 1: product register p ← sext16(diff_in) × sext16(wt_in); pvalid ← 1.
  - Stage 2: when pvalid=1, acc ← acc + sext(p).
  - remaining decrements on each accepted beat. On the beat that makes remaining 0, go to DRAIN (in_ready drops the next cycle).
- DRAIN: one cycle; stage 2 consumes the last product. Go to DONE.
- DONE:
  - out_valid=1.
  - acc_out = clamp(acc, −2^(OUT_W−1), 2^(OUT_W−1)−1).
  - sat_flag=1 iff clamping occurred.
  - acc_out and sat_flag are registered and held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: go to IDLE with out_valid=0 the next cycle.
- Latency: if the last beat is accepted at cycle t, out_valid=1 at cycle t+2.
- start handling:
  - start in any state other than IDLE is ignored; len is not re-sampled.
  - start asserted in the same cycle as the output handshake is ignored; it must be re-asserted in IDLE.
- Arithmetic:
  - Two's complement throughout; no rounding.
  - The −128×−128 = +16384 product is representable.
  - The accumulator never wraps under the parameter constraint.
- in_ready is 0 in IDLE, DRAIN and DONE, so no input is accepted during backpressure.

Test Plan:
- Basic dot product: len=3, beats (diff,wt)=(5,2),(−3,4),(127,−1) back-to-back → acc_out=−129, sat_flag=0, out_valid exactly 2 cycles after the third accept.
- Positive saturation: len=4, four beats of (−128,−128) → acc 65536, acc_out=32767, sat_flag=1. Negative saturation: len=4, four beats of (−128,127) → acc_out=−32768, sat_flag=1.
- Input bubbles: repeat the basic dot product with in_valid low for 1–3 random cycles between beats → identical result; remaining counts only accepted beats.
- Output backpressure: hold out_ready=0 for 5 cycles in DONE → acc_out/sat_flag stable, in_ready=0, busy=1. Then pulse out_ready → IDLE next cycle. A start pulsed during DONE is ignored.
- Zero length: start with len=0 → out_valid at start+2, acc_out=0, sat_flag=0, and in_ready never asserts.
- Reset mid-job: assert rst_n=0 after 2 of 5 beats → all outputs 0 immediately. Release reset, run len=1 with (10,10) → acc_out=100.
